// File: rtl/config_reg_arbiter.sv
// Round-robin arbiter sharing the single config_reg port between host (0) and calibration engine (1).
// Latency: grant edge -> ACCESS (1 cycle) -> RESP with ack (1 cycle); one transaction per 3 cycles.
// Backpressure: requesters hold req with a stable command until ack; CFG_ARB_WPROT_EN enables write-protect for requester 1.
module config_reg_arbiter #(
    parameter int                       ADDR_W  = 3,
    parameter int                       DATA_W  = 16,
    parameter logic [(1<<ADDR_W)-1:0]   WP_MASK = 8'b1011_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic                wr0,
    input  logic                wr1,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic [DATA_W-1:0]   wdata1,
    output logic                ack0,
    output logic                ack1,
    output logic [DATA_W-1:0]   rdata0,
    output logic [DATA_W-1:0]   rdata1,
    output logic                err0,
    output logic                err1,
    output logic                busy,
    output logic                cfg_write,
    output logic [ADDR_W-1:0]   cfg_address,
    output logic [DATA_W-1:0]   cfg_data_in,
    input  logic [DATA_W-1:0]   cfg_data_out
);

`ifdef CFG_ARB_WPROT_EN
    localparam bit WPROT_ON = 1'b1;
`else
    localparam bit WPROT_ON = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              r_state;
    logic                r_ptr;      // 0 favours requester 0, 1 favours requester 1
    logic                r_gnt;      // requester owning the current transaction
    logic                r_wr;       // current transaction is a write (even if suppressed)
    logic                r_prot;     // current write is blocked by write-protect
    logic                r_ack0;
    logic                r_ack1;
    logic                r_err1;
    logic                r_busy;
    logic                r_cfg_write;
    logic [ADDR_W-1:0]   r_cfg_address;
    logic [DATA_W-1:0]   r_cfg_data_in;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic                w_pick1;
    logic                w_wr;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_prot;

    // Requester 1 wins when it is alone or when the pointer favours it
    assign w_pick1 = req1 & (~req0 | r_ptr);
    assign w_wr    = w_pick1 ? wr1    : wr0;
    assign w_addr  = w_pick1 ? addr1  : addr0;
    assign w_wdata = w_pick1 ? wdata1 : wdata0;
    // Only requester 1 writes are ever protected
    assign w_prot  = WPROT_ON & w_pick1 & wr1 & WP_MASK[addr1];

    // Arbitration FSM with all outputs registered; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_ptr         <= 1'b0;
            r_gnt         <= 1'b0;
            r_wr          <= 1'b0;
            r_prot        <= 1'b0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_err1        <= 1'b0;
            r_busy        <= 1'b0;
            r_cfg_write   <= 1'b0;
            r_cfg_address <= '0;
            r_cfg_data_in <= '0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0 | req1) begin
                        r_gnt         <= w_pick1;
                        r_wr          <= w_wr;
                        r_prot        <= w_prot;
                        r_cfg_address <= w_addr;
                        r_cfg_data_in <= w_wdata;
                        r_cfg_write   <= w_wr & ~w_prot;
                        r_busy        <= 1'b1;
                        r_state       <= ACCESS;
                    end else begin
                        r_cfg_write   <= 1'b0;
                    end
                end
                ACCESS: begin
                    r_cfg_write <= 1'b0;
                    if (!r_wr) begin
                        if (r_gnt) r_rdata1 <= cfg_data_out;
                        else       r_rdata0 <= cfg_data_out;
                    end
                    r_ack0  <= ~r_gnt;
                    r_ack1  <= r_gnt;
                    r_err1  <= r_gnt & r_prot;
                    r_state <= RESP;
                end
                RESP: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ptr   <= ~r_gnt;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign err0        = 1'b0;
    assign err1        = r_err1;
    assign busy        = r_busy;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign cfg_write   = r_cfg_write;
    assign cfg_address = r_cfg_address;
    assign cfg_data_in = r_cfg_data_in;

endmodule

// File: tb/tb_config_reg_arbiter.sv
// Directed bench for config_reg_arbiter with a behavioural config_reg and an expected-response queue.
// Latency: checks ack two cycles after grant and a three-cycle spacing for back-to-back grants.
// Backpressure: requesters hold req until ack, then drop it on the ack-sampling edge.
module tb_config_reg_arbiter;

`ifdef CFG_ARB_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif
    localparam logic [7:0] WP = 8'b1011_0000;

    typedef struct packed {
        logic        id;
        logic [15:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, wr0, wr1;
    logic [2:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, err0, err1, busy, cfg_write;
    logic [15:0] rdata0, rdata1;
    logic [2:0]  cfg_address;
    logic [15:0] cfg_data_in, cfg_data_out;

    // Stand-in for config_reg: not cleared by the arbiter's reset
    logic [15:0] mem [8] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
                             16'hABCD, 16'h0000, 16'h0000, 16'h0001};
    // Bench reference contents
    logic [15:0] ref_mem [8] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
                                 16'hABCD, 16'h0000, 16'h0000, 16'h0001};
    logic [15:0] last_rd [2];
    exp_t        q [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (cfg_write) mem[cfg_address] <= cfg_data_in;
    assign cfg_data_out = mem[cfg_address];

    config_reg_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1), .busy(busy),
        .cfg_write(cfg_write), .cfg_address(cfg_address),
        .cfg_data_in(cfg_data_in), .cfg_data_out(cfg_data_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drive(input logic id, input logic v, input logic wr, input logic [2:0] a, input logic [15:0] d);
        if (id) begin req1 = v; wr1 = wr; addr1 = a; wdata1 = d; end
        else    begin req0 = v; wr0 = wr; addr0 = a; wdata0 = d; end
    endtask

    // Queue the expected response and update the reference model
    task automatic push_exp(input logic id, input logic wr, input logic [2:0] a, input logic [15:0] d);
        exp_t e;
        e.id  = id;
        e.err = WPROT && id && wr && WP[a];
        if (wr) begin
            e.rd = last_rd[id];
            if (!e.err) ref_mem[a] = d;
        end else begin
            e.rd = ref_mem[a];
            last_rd[id] = ref_mem[a];
        end
        q.push_back(e);
    endtask

    // Wait (bounded) for any ack, then compare against the queue head
    task automatic wait_ack(input string tag, input int exp_lat);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack0 || ack1) && n < 8);
        chk({tag, "_lat"}, n, exp_lat);
        if (q.size() == 0) begin
            chk({tag, "_queue_empty"}, 1, 0);
        end else begin
            e = q.pop_front();
            chk({tag, "_ack0"}, ack0, !e.id);
            chk({tag, "_ack1"}, ack1, e.id);
            chk({tag, "_rdata"}, e.id ? rdata1 : rdata0, e.rd);
            chk({tag, "_err0"}, err0, 1'b0);
            chk({tag, "_err1"}, err1, e.id & e.err);
        end
    endtask

    task automatic txn(input string tag, input logic id, input logic wr, input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        push_exp(id, wr, a, d);
        drive(id, 1'b1, wr, a, d);
        wait_ack(tag, 2);
        drive(id, 1'b0, 1'b0, 3'd0, 16'h0);
    endtask

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        #1;
        // Reset state
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_write", cfg_write, 0);
        chk("rst_cfg_address", cfg_address, 0);
        chk("rst_cfg_data_in", cfg_data_in, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_err1", err1, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Requester 0 reads every address
        for (int i = 0; i < 8; i++) txn($sformatf("rd0_a%0d", i), 1'b0, 1'b0, 3'(i), 16'h0);

        // Write by 0, read back by 1, then scan all
        txn("wr0_a6", 1'b0, 1'b1, 3'd6, 16'h1234);
        txn("rd1_a6", 1'b1, 1'b0, 3'd6, 16'h0);
        for (int i = 0; i < 8; i++) txn($sformatf("scan_a%0d", i), 1'b0, 1'b0, 3'(i), 16'h0);

        // Write-protect behaviour on address 7
        txn("wr1_a7", 1'b1, 1'b1, 3'd7, 16'h0000);
        txn("rd0_a7_after_wr1", 1'b0, 1'b0, 3'd7, 16'h0);
        txn("wr0_a7", 1'b0, 1'b1, 3'd7, 16'h0000);
        txn("rd1_a7_after_wr0", 1'b1, 1'b0, 3'd7, 16'h0);

        // Reset during ACCESS of a write aborts it
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 3'd2, 16'h00FF);
        @(negedge clk);
        chk("abort_busy_access", busy, 1);
        chk("abort_cfg_write_access", cfg_write, 1);
        chk("abort_cfg_address", cfg_address, 2);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        last_rd[0] = '0; last_rd[1] = '0;
        #1;
        chk("abort_cfg_write_now", cfg_write, 0);
        chk("abort_busy_now", busy, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_no_ack", {ack0, ack1}, 2'b00);
        end
        reset = 1'b1;
        txn("rd0_a2_after_abort", 1'b0, 1'b0, 3'd2, 16'h0);

        // Both requesters held high: grants alternate starting with 0
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 5; k++) push_exp(1'(k % 2), 1'b0, 3'd4, 16'h0);
        drive(1'b0, 1'b1, 1'b0, 3'd4, 16'h0);
        drive(1'b1, 1'b1, 1'b0, 3'd4, 16'h0);
        for (int k = 0; k < 5; k++) begin
            wait_ack($sformatf("rr_%0d", k), k == 0 ? 2 : 3);
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_quiet", {ack0, ack1, busy}, 3'b000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/config_reg_arbiter.md
Name: config_reg_arbiter

Overview:
- Shares the single port of the 8 x 16-bit configuration register file (config_reg) between two requesters: requester 0 (host bus) and requester 1 (calibration engine).
- Round-robin arbitration with a req/ack handshake per requester; one transaction (read or write) at a time.
- Drives config_reg's write, address and data_in inputs; samples its data_out.

Parameters:
- ADDR_W, 3, register address width (8 registers).
- DATA_W, 16, register data width.
- WP_MASK, 8'b1011_0000, per-address write-protect mask for requester 1 (bit n = address n); used only with CFG_ARB_WPROT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0, req1  in  1  request; held with command stable until ack.
- wr0, wr1  in  1  1 = write, 0 = read.
- addr0, addr1  in  ADDR_W  target register.
- wdata0, wdata1  in  DATA_W  write data.
- ack0, ack1  out  1  one-cycle completion pulse.
- rdata0, rdata1  out  DATA_W  read result, valid while the matching ack is high.
- err0, err1  out  1  protection violation, pulses with ack.
- busy  out  1  high in ACCESS and RESP.
- cfg_write  out  1  to config_reg write.
- cfg_address  out  ADDR_W  to config_reg address.
- cfg_data_in  out  DATA_W  to config_reg data_in.
- cfg_data_out  in  DATA_W  from config_reg data_out (combinational from address).

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all ack*, err*, busy, cfg_write = 0; cfg_address=0, cfg_data_in=0, rdata*=0.
  - Round-robin pointer favours requester 0.
  - Reset mid-transaction aborts it: no ack, no write issued after reset asserts.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, grant one. Single requester: it wins. Both: the pointer's favoured requester wins.
  - Latch its wr/addr/wdata into cfg_address, cfg_data_in and cfg_write (=wr), then go to ACCESS.
  - No request: stay in IDLE, cfg_write=0.
- ACCESS (1 cycle):
  - cfg_write is high for a write; config_reg captures it on the closing edge.
  - For a read, cfg_data_out is sampled on the closing edge into the granted requester's rdata.
  - Go to RESP.
- RESP (1 cycle):
  - cfg_write=0.
  - Granted ack=1; the other ack stays 0.
  - Pointer flips to favour the non-granted requester.
  - Go to IDLE.
- Latency: req high at edge N (in IDLE) -> ACCESS during cycle N+1 -> ack during cycle N+2. Back-to-back throughput is one transaction per 3 cycles.
- Requester rules:
  - Must drop req, or present a new command, on the edge where ack is sampled.
  - If req is still high in IDLE, it is a new transaction.
  - Command changes while req is high and not yet granted are allowed; the value latched is the one at the grant edge.
- rdata updates only on reads; it holds its value across writes and idle cycles.
- A requester dropping req before grant: no transaction, no ack.
- Address wrap: none. Any ADDR_W value is legal.

Optional Feature:
- Macro: CFG_ARB_WPROT_EN.
- Defined:
  - A write from requester 1 to an address with WP_MASK[addr]=1 is suppressed: cfg_write stays 0 in ACCESS, config_reg is unchanged.
  - The transaction still completes with ack1, and err1=1 in the same cycle.
  - Requester 0 is never protected; err0 is always 0.
- Undefined: all writes pass; err0 = err1 = 0 constant. Ports exist in both builds.

Test Plan:
- Reset, then req0 reads addresses 0..7 -> rdata0 = FFFF, 0, 0, 0, ABCD, 0, 0, 0001; each ack0 exactly 2 cycles after grant.
- req0 writes addr 6 = 0x1234, then req1 reads addr 6 -> rdata1 = 0x1234; no other address changes (re-read all 8).
- req0 and req1 both held high after reset, each reading addr 4 -> ack0 first, then ack1; repeated simultaneous requests alternate 1, 0, 1.
- Assert reset during ACCESS of a write to addr 2 = 0x00FF -> no ack; cfg_write low immediately; after release, addr 2 reads 0x0000.
- With CFG_ARB_WPROT_EN: req1 writes addr 7 = 0x0000 -> ack1 and err1 pulse; addr 7 still reads 0x0001. req0 writes addr 7 = 0x0000 -> err0=0; addr 7 reads 0x0000.
- Without CFG_ARB_WPROT_EN: same req1 write to addr 7 -> err1=0; addr 7 reads 0x0000.
